// File: rtl/stage_data_wb_if.sv
// Write-group and read-port bundle for the stage coefficient buffer.
interface stage_data_wb_if #(
   parameter int DW = 12,
   parameter int AW = 7
);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] A0;
   logic [AW-1:0] A1;
   logic [AW-1:0] A2;
   logic [AW-1:0] A3;
   logic [DW-1:0] D0;
   logic [DW-1:0] D1;
   logic [DW-1:0] D2;
   logic [DW-1:0] D3;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;

   modport master (
      output in_valid, A0, A1, A2, A3,
      output D0, D1, D2, D3, rd_addr,
      input  in_ready, rd_data
   );

   modport slave (
      input  in_valid, A0, A1, A2, A3,
      input  D0, D1, D2, D3, rd_addr,
      output in_ready, rd_data
   );
endinterface

// File: rtl/stage_data_wb.sv
// Write-back side of the stage coefficient buffer: reduces 4-lane results
// mod Q, stores them in a 128 x 12 array and tracks stage completion.
module stage_data_wb #(
   parameter int DW     = 12,
   parameter int AW     = 7,
   parameter int Q      = 3329,
   parameter int GROUPS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            SEN,
   input  logic            start,
   stage_data_wb_if.slave  bus,
   output logic            busy,
   output logic            done,
   output logic            conflict,
   output logic [5:0]      grp_cnt
);
   localparam int            DEPTH = 1 << AW;
   localparam logic [DW-1:0] QV    = DW'(Q);
   localparam logic [5:0]    LAST  = 6'(GROUPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    grp_q, grp_d;
   logic          conf_q, conf_d;
   logic          pv_q, pv_d;
   logic [AW-1:0] pa_q [4];
   logic [AW-1:0] pa_d [4];
   logic [DW-1:0] pd_q [4];
   logic [DW-1:0] pd_d [4];
   logic [DW-1:0] rd_q, rd_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic [AW-1:0] a_in [4];
   logic [DW-1:0] d_in [4];
   logic          accept;
   logic          lane_eq;

   assign a_in[0] = bus.A0;
   assign a_in[1] = bus.A1;
   assign a_in[2] = bus.A2;
   assign a_in[3] = bus.A3;
   assign d_in[0] = bus.D0;
   assign d_in[1] = bus.D1;
   assign d_in[2] = bus.D2;
   assign d_in[3] = bus.D3;

   assign bus.in_ready = SEN & (state_q == S_WRITE);
   assign accept       = bus.in_valid & bus.in_ready;

   assign lane_eq = (a_in[0] == a_in[1]) | (a_in[0] == a_in[2])
                  | (a_in[0] == a_in[3]) | (a_in[1] == a_in[2])
                  | (a_in[1] == a_in[3]) | (a_in[2] == a_in[3]);

   assign busy        = (state_q == S_WRITE) | (state_q == S_FLUSH);
   assign done        = (state_q == S_DONE);
   assign conflict    = conf_q;
   assign grp_cnt     = grp_q;
   assign bus.rd_data = rd_q;

   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      conf_d  = conf_q;
      if (SEN) begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = S_WRITE;
                  grp_d   = '0;
                  conf_d  = 1'b0;
               end
            end
            S_WRITE: begin
               if (accept) begin
                  grp_d  = grp_q + 6'd1;
                  conf_d = conf_q | lane_eq;
                  if (grp_q == LAST) state_d = S_FLUSH;
               end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // single conditional subtraction; inputs >= 2Q stay partially reduced
   always_comb begin
      pv_d = pv_q;
      pa_d = pa_q;
      pd_d = pd_q;
      if (SEN) pv_d = accept;
      if (accept) begin
         for (int i = 0; i < 4; i++) begin
            pa_d[i] = a_in[i];
            pd_d[i] = (d_in[i] >= QV) ? d_in[i] - QV : d_in[i];
         end
      end
   end

   always_comb begin
      rd_d = rd_q;
      if (SEN) rd_d = mem_q[bus.rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grp_q   <= '0;
         conf_q  <= 1'b0;
         pv_q    <= 1'b0;
         rd_q    <= '0;
         for (int i = 0; i < 4; i++) begin
            pa_q[i] <= '0;
            pd_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         conf_q  <= conf_d;
         pv_q    <= pv_d;
         rd_q    <= rd_d;
         pa_q    <= pa_d;
         pd_q    <= pd_d;
      end
   end

   // later lanes overwrite earlier ones on an address collision
   always_ff @(posedge clk) begin
      if (SEN && pv_q) begin
         mem_q[pa_q[0]] <= pd_q[0];
         mem_q[pa_q[1]] <= pd_q[1];
         mem_q[pa_q[2]] <= pd_q[2];
         mem_q[pa_q[3]] <= pd_q[3];
      end
   end
endmodule

// File: tb/tb_stage_data_wb.sv
// Directed plus randomized bench for stage_data_wb against a
// behavioural array model of the coefficient store.
module tb_stage_data_wb;
   typedef int quad_t [4];

   logic       clk;
   logic       rst_n;
   logic       SEN;
   logic       start;
   logic       busy;
   logic       done;
   logic       conflict;
   logic [5:0] grp_cnt;

   stage_data_wb_if bus ();

   stage_data_wb dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SEN      (SEN),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .conflict (conflict),
      .grp_cnt  (grp_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ref_mem [128];
   int ref_grp;
   bit ref_conf;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int red(input int d);
      return (d >= 3329) ? d - 3329 : d;
   endfunction

   task automatic group(input quad_t a, input quad_t d, input bit commit);
      bus.A0 = 7'(a[0]); bus.A1 = 7'(a[1]);
      bus.A2 = 7'(a[2]); bus.A3 = 7'(a[3]);
      bus.D0 = 12'(d[0]); bus.D1 = 12'(d[1]);
      bus.D2 = 12'(d[2]); bus.D3 = 12'(d[3]);
      bus.in_valid = 1'b1;
      #1;
      chk("in_ready_wr", int'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      ref_grp++;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (a[i] == a[j]) ref_conf = 1'b1;
      if (commit)
         for (int i = 0; i < 4; i++) ref_mem[a[i]] = red(d[i]);
      chk("grp_cnt", int'(grp_cnt), ref_grp);
   endtask

   task automatic rand_group(input bit commit);
      quad_t a, d;
      for (int i = 0; i < 4; i++) begin
         a[i] = int'($urandom_range(0, 127));
         d[i] = int'($urandom_range(0, 4095));
      end
      group(a, d, commit);
   endtask

   task automatic finish_stage();
      while (ref_grp < 32) rand_group(1'b1);
      chk("flush_busy", int'(busy), 1);
      chk("flush_ready", int'(bus.in_ready), 0);
      chk("flush_done", int'(done), 0);
      tick();
      chk("done", int'(done), 1);
      chk("done_busy", int'(busy), 0);
      chk("done_grp", int'(grp_cnt), 32);
      chk("done_conf", int'(conflict), int'(ref_conf));
   endtask

   task automatic read(input int addr, input int exp, input string tag);
      bus.rd_addr = 7'(addr);
      tick();
      chk(tag, int'(bus.rd_data), exp);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      ref_grp = 0;
      ref_conf = 1'b0;
      chk("start_busy", int'(busy), 1);
      chk("start_grp", int'(grp_cnt), 0);
      chk("start_conf", int'(conflict), 0);
   endtask

   initial begin
      quad_t ga, gd;
      int old7;
      rst_n = 1'b1;
      SEN = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.rd_addr = '0;
      bus.A0 = '0; bus.A1 = '0; bus.A2 = '0; bus.A3 = '0;
      bus.D0 = '0; bus.D1 = '0; bus.D2 = '0; bus.D3 = '0;
      ref_grp = 0;
      ref_conf = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", int'(bus.in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_conf", int'(conflict), 0);
      chk("rst_grp", int'(grp_cnt), 0);
      chk("rst_rd", int'(bus.rd_data), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // stage A: linear fill, data equals address
      do_start();
      for (int k = 0; k < 32; k++) begin
         ga = '{4*k, 4*k+1, 4*k+2, 4*k+3};
         gd = '{4*k, 4*k+1, 4*k+2, 4*k+3};
         group(ga, gd, 1'b1);
      end
      finish_stage();
      for (int i = 0; i < 128; i++) read(i, i, "fill_rd");

      // stage B: reduction, collision, SEN freeze
      do_start();
      ga = '{20, 21, 22, 23};
      gd = '{3328, 3329, 4095, 0};
      group(ga, gd, 1'b1);
      ga = '{10, 11, 10, 12};
      gd = '{100, 55, 200, 66};
      group(ga, gd, 1'b1);
      chk("conflict_set", int'(conflict), 1);
      tick();
      read(20, 3328, "red_3328");
      read(21, 0, "red_3329");
      read(22, 766, "red_4095");
      read(23, 0, "red_0");
      read(10, 200, "lane_prio");
      SEN = 1'b0;
      bus.in_valid = 1'b1;
      bus.rd_addr = 7'd20;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sen_ready", int'(bus.in_ready), 0);
         tick();
         chk("sen_grp", int'(grp_cnt), 2);
         chk("sen_rd_hold", int'(bus.rd_data), 200);
         chk("sen_busy", int'(busy), 1);
      end
      bus.in_valid = 1'b0;
      SEN = 1'b1;
      finish_stage();
      chk("conf_sticky", int'(conflict), 1);

      // stage C: read-during-write, then reset with a write pending
      do_start();
      old7 = ref_mem[7];
      bus.rd_addr = 7'd7;
      ga = '{7, 50, 51, 52};
      gd = '{999, 1, 2, 3};
      group(ga, gd, 1'b1);
      tick();
      chk("rdw_old", int'(bus.rd_data), old7);
      tick();
      chk("rdw_new", int'(bus.rd_data), ref_mem[7]);
      for (int i = 0; i < 3; i++) rand_group(1'b1);
      ga = '{40, 41, 42, 43};
      for (int i = 0; i < 4; i++) gd[i] = (ref_mem[40+i] + 17) % 3000;
      group(ga, gd, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", int'(bus.in_ready), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_grp", int'(grp_cnt), 0);
      chk("mid_rst_done", int'(done), 0);
      tick();
      rst_n = 1'b1;
      ref_grp = 0;
      ref_conf = 1'b0;
      for (int i = 0; i < 4; i++) read(40 + i, ref_mem[40+i], "drop_pend");
      chk("idle_busy", int'(busy), 0);

      // stage D: fully random stage checked against the model
      do_start();
      finish_stage();
      for (int i = 0; i < 128; i++) read(i, ref_mem[i], "rand_rd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
